// File: rtl/active_resp.sv
// ACTIVE entry responder: waits for the remote ACTIVE_entry_req on the sideband,
// echoes its payload back in an ACTIVE_entry_resp, and reports done or error.
package active_resp_pkg;
  typedef enum logic [3:0] {
    SB_NOP            = 4'h0,
    ACTIVE_entry_req  = 4'h1,
    ACTIVE_entry_resp = 4'h2,
    PM_entry_req      = 4'h3,
    SB_error_msg      = 4'h4
  } SB_msg_t;
endpackage

module active_resp
  import active_resp_pkg::*;
#(
  parameter int MAX_UNEXP = 4
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          enable_i,
  input  SB_msg_t       SB_RX_msg_i,
  input  logic [63:0]   SB_RX_dataBus_i,
  input  logic          SB_RX_msg_valid_i,
  output logic          SB_RX_msg_req_o,
  output SB_msg_t       SB_TX_msg_o,
  output logic [63:0]   SB_TX_dataBus_o,
  output logic          SB_TX_msg_valid_o,
  input  logic          SB_TX_msg_sendNextFlag_i,
  input  logic          SBmessage_retry_timeout_flag,
  output logic          reset_SBmessage_retry_timeout,
  output logic          reset_state_timeout_counter_o,
  output logic          ACTIVE_RESP_done_o,
  output logic          ACTIVE_RESP_error_o
);
  // state     | meaning
  // IDLE      | not granted; everything cleared
  // WAIT_REQ  | popping RX messages until ACTIVE_entry_req arrives
  // SEND_RESP | offering ACTIVE_entry_resp carrying the echoed payload
  // DONE      | response delivered; still absorbs remote retries
  // ERROR     | timeout or too many unexpected messages; sticky until disabled
  typedef enum logic [2:0] {IDLE, WAIT_REQ, SEND_RESP, DONE, ERROR} state_t;

  localparam int CW = $clog2(MAX_UNEXP + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  unexp_q, unexp_d;
  logic [63:0]    echo_q, echo_d;
  logic           rx_req_q, rx_req_d;
  SB_msg_t        tx_msg_q, tx_msg_d;
  logic [63:0]    tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           rst_retry_q, rst_retry_d;
  logic           rst_state_q, rst_state_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic consumed, is_req;

  assign consumed = rx_req_q & SB_RX_msg_valid_i;
  assign is_req   = (SB_RX_msg_i == ACTIVE_entry_req);

  always_comb begin
    state_d     = state_q;
    unexp_d     = unexp_q;
    echo_d      = echo_q;
    rx_req_d    = rx_req_q;
    tx_msg_d    = tx_msg_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    rst_retry_d = 1'b0;
    rst_state_d = 1'b0;
    done_d      = done_q;
    error_d     = error_q;

    if (!enable_i) begin
      // Withdrawal also drops an unaccepted TX offer.
      state_d    = IDLE;
      unexp_d    = '0;
      echo_d     = '0;
      rx_req_d   = 1'b0;
      tx_msg_d   = SB_NOP;
      tx_data_d  = '0;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = WAIT_REQ;
          rx_req_d    = 1'b1;
          rst_retry_d = 1'b1;
          rst_state_d = 1'b1;
        end
        WAIT_REQ: begin
          if (consumed && is_req) begin
            state_d    = SEND_RESP;
            echo_d     = SB_RX_dataBus_i;
            unexp_d    = '0;
            rx_req_d   = 1'b0;
            tx_valid_d = 1'b1;
            tx_msg_d   = ACTIVE_entry_resp;
            tx_data_d  = SB_RX_dataBus_i;
          end else if (SBmessage_retry_timeout_flag) begin
            state_d  = ERROR;
            rx_req_d = 1'b0;
            error_d  = 1'b1;
          end else if (consumed) begin
            if (unexp_q != CW'(MAX_UNEXP)) unexp_d = unexp_q + CW'(1);
            if (unexp_q >= CW'(MAX_UNEXP - 1)) begin
              state_d  = ERROR;
              rx_req_d = 1'b0;
              error_d  = 1'b1;
            end
          end
        end
        SEND_RESP: begin
          if (SB_TX_msg_sendNextFlag_i) begin
            state_d    = DONE;
            tx_valid_d = 1'b0;
            tx_msg_d   = SB_NOP;
            tx_data_d  = '0;
            rx_req_d   = 1'b1;
            done_d     = 1'b1;
          end
        end
        DONE: begin
          // A repeated request means the remote missed our response.
          if (consumed && is_req) begin
            state_d    = SEND_RESP;
            echo_d     = SB_RX_dataBus_i;
            rx_req_d   = 1'b0;
            done_d     = 1'b0;
            tx_valid_d = 1'b1;
            tx_msg_d   = ACTIVE_entry_resp;
            tx_data_d  = SB_RX_dataBus_i;
          end
        end
        ERROR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      unexp_q     <= '0;
      echo_q      <= '0;
      rx_req_q    <= 1'b0;
      tx_msg_q    <= SB_NOP;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rst_retry_q <= 1'b0;
      rst_state_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      unexp_q     <= unexp_d;
      echo_q      <= echo_d;
      rx_req_q    <= rx_req_d;
      tx_msg_q    <= tx_msg_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rst_retry_q <= rst_retry_d;
      rst_state_q <= rst_state_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign SB_RX_msg_req_o               = rx_req_q;
  assign SB_TX_msg_o                   = tx_msg_q;
  assign SB_TX_dataBus_o               = tx_data_q;
  assign SB_TX_msg_valid_o             = tx_valid_q;
  assign reset_SBmessage_retry_timeout = rst_retry_q;
  assign reset_state_timeout_counter_o = rst_state_q;
  assign ACTIVE_RESP_done_o            = done_q;
  assign ACTIVE_RESP_error_o           = error_q;
endmodule

// File: tb/tb_active_resp.sv
// Directed bench for active_resp; expected response payloads go through a
// scoreboard queue and are checked when the DUT offers and hands off the response.
module tb_active_resp;
  import active_resp_pkg::*;

  logic        clk_100MHz = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_i = 1'b0;
  SB_msg_t     SB_RX_msg_i = SB_NOP;
  logic [63:0] SB_RX_dataBus_i = '0;
  logic        SB_RX_msg_valid_i = 1'b0;
  logic        SB_RX_msg_req_o;
  SB_msg_t     SB_TX_msg_o;
  logic [63:0] SB_TX_dataBus_o;
  logic        SB_TX_msg_valid_o;
  logic        SB_TX_msg_sendNextFlag_i = 1'b0;
  logic        SBmessage_retry_timeout_flag = 1'b0;
  logic        reset_SBmessage_retry_timeout;
  logic        reset_state_timeout_counter_o;
  logic        ACTIVE_RESP_done_o;
  logic        ACTIVE_RESP_error_o;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];

  active_resp #(.MAX_UNEXP(4)) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable_i(enable_i),
    .SB_RX_msg_i(SB_RX_msg_i), .SB_RX_dataBus_i(SB_RX_dataBus_i),
    .SB_RX_msg_valid_i(SB_RX_msg_valid_i), .SB_RX_msg_req_o(SB_RX_msg_req_o),
    .SB_TX_msg_o(SB_TX_msg_o), .SB_TX_dataBus_o(SB_TX_dataBus_o),
    .SB_TX_msg_valid_o(SB_TX_msg_valid_o),
    .SB_TX_msg_sendNextFlag_i(SB_TX_msg_sendNextFlag_i),
    .SBmessage_retry_timeout_flag(SBmessage_retry_timeout_flag),
    .reset_SBmessage_retry_timeout(reset_SBmessage_retry_timeout),
    .reset_state_timeout_counter_o(reset_state_timeout_counter_o),
    .ACTIVE_RESP_done_o(ACTIVE_RESP_done_o),
    .ACTIVE_RESP_error_o(ACTIVE_RESP_error_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " idle"}, {SB_RX_msg_req_o, SB_TX_msg_valid_o, reset_SBmessage_retry_timeout,
         reset_state_timeout_counter_o, ACTIVE_RESP_done_o, ACTIVE_RESP_error_o}, '0);
    chk({tag, " txmsg"}, 64'(SB_TX_msg_o), 64'(SB_NOP));
    chk({tag, " txdata"}, SB_TX_dataBus_o, '0);
  endtask

  // Present one RX message and keep it valid until the DUT pops it.
  task automatic send_rx(input string tag, input SB_msg_t msg, input logic [63:0] data);
    bit popped = 0;
    SB_RX_msg_i = msg;
    SB_RX_dataBus_i = data;
    SB_RX_msg_valid_i = 1'b1;
    if (msg == ACTIVE_entry_req) exp_q.push_back(data);
    for (int i = 0; i < 10 && !popped; i++) begin
      popped = SB_RX_msg_req_o;
      tick();
    end
    SB_RX_msg_valid_i = 1'b0;
    SB_RX_msg_i = SB_NOP;
    if (!popped) chk({tag, " pop timeout"}, 64'(0), 64'(1));
  endtask

  // Hold the offer for `hold` cycles checking it, then accept it.
  task automatic accept(input string tag, input int hold);
    logic [63:0] exp;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 64'(0), 64'(1));
      return;
    end
    exp = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk({tag, " valid"}, 64'(SB_TX_msg_valid_o), 64'(1));
      chk({tag, " msg"}, 64'(SB_TX_msg_o), 64'(ACTIVE_entry_resp));
      chk({tag, " data"}, SB_TX_dataBus_o, exp);
      chk({tag, " done low"}, 64'(ACTIVE_RESP_done_o), 64'(0));
      if (i == hold) SB_TX_msg_sendNextFlag_i = 1'b1;
      tick();
    end
    SB_TX_msg_sendNextFlag_i = 1'b0;
    chk({tag, " valid dropped"}, 64'(SB_TX_msg_valid_o), 64'(0));
    chk({tag, " done"}, 64'(ACTIVE_RESP_done_o), 64'(1));
    chk({tag, " no error"}, 64'(ACTIVE_RESP_error_o), 64'(0));
  endtask

  task automatic restart();
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    tick();
  endtask

  initial begin
    #3;
    chk_idle_outs("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk_idle_outs("post-reset disabled");

    // Basic handshake with delayed request and delayed acceptance.
    enable_i = 1'b1;
    tick();
    chk("enter pulses", {62'd0, reset_state_timeout_counter_o, reset_SBmessage_retry_timeout}, 64'd3);
    chk("wait rx_req", 64'(SB_RX_msg_req_o), 64'(1));
    tick();
    chk("pulses one cycle", {62'd0, reset_state_timeout_counter_o, reset_SBmessage_retry_timeout}, 64'd0);
    tick();
    send_rx("basic req", ACTIVE_entry_req, 64'hDEAD_BEEF_0000_0001);
    chk("send rx_req low", 64'(SB_RX_msg_req_o), 64'(0));
    accept("basic", 1);
    chk("done rx_req", 64'(SB_RX_msg_req_o), 64'(1));

    // Retry absorption in DONE.
    send_rx("done other", PM_entry_req, 64'h55);
    chk("done kept", 64'(ACTIVE_RESP_done_o), 64'(1));
    send_rx("dup req", ACTIVE_entry_req, 64'h2);
    accept("dup", 0);
    tick();
    chk("sendNext ignored in done", 64'(SB_TX_msg_valid_o), 64'(0));

    // Four unexpected messages -> error.
    restart();
    send_rx("unexp1", SB_NOP, 64'h1);
    send_rx("unexp2", PM_entry_req, 64'h2);
    send_rx("unexp3", SB_error_msg, 64'h3);
    chk("3 unexp no error", 64'(ACTIVE_RESP_error_o), 64'(0));
    send_rx("unexp4", PM_entry_req, 64'h4);
    chk("4 unexp error", 64'(ACTIVE_RESP_error_o), 64'(1));
    chk("error rx_req", 64'(SB_RX_msg_req_o), 64'(0));
    chk("error not done", 64'(ACTIVE_RESP_done_o), 64'(0));
    tick(); tick();
    chk("error sticky", 64'(ACTIVE_RESP_error_o), 64'(1));

    // Three unexpected then a request completes normally.
    restart();
    chk("error cleared", 64'(ACTIVE_RESP_error_o), 64'(0));
    send_rx("u1", PM_entry_req, 64'h1);
    send_rx("u2", PM_entry_req, 64'h2);
    send_rx("u3", PM_entry_req, 64'h3);
    send_rx("req after 3", ACTIVE_entry_req, 64'h0123_4567_89AB_CDEF);
    accept("after 3", 0);

    // Request beats timeout in the same cycle.
    restart();
    SBmessage_retry_timeout_flag = 1'b1;
    send_rx("req+timeout", ACTIVE_entry_req, 64'hA5A5_A5A5_5A5A_5A5A);
    SBmessage_retry_timeout_flag = 1'b0;
    chk("req+timeout no error", 64'(ACTIVE_RESP_error_o), 64'(0));
    accept("req+timeout", 2);

    // Timeout alone.
    restart();
    SBmessage_retry_timeout_flag = 1'b1;
    tick();
    SBmessage_retry_timeout_flag = 1'b0;
    chk("timeout error", 64'(ACTIVE_RESP_error_o), 64'(1));
    chk("timeout not done", 64'(ACTIVE_RESP_done_o), 64'(0));

    // Withdraw while offering.
    restart();
    send_rx("withdraw req", ACTIVE_entry_req, 64'hFFFF_0000_FFFF_0000);
    chk("offer present", 64'(SB_TX_msg_valid_o), 64'(1));
    void'(exp_q.pop_front());
    enable_i = 1'b0;
    tick();
    chk_idle_outs("withdrawn");

    // Async reset mid-WAIT_REQ, then restart on first enabled edge.
    enable_i = 1'b1;
    tick();
    chk("wait before reset", 64'(SB_RX_msg_req_o), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outs("async reset");
    #3;
    reset_n = 1'b1;
    tick();
    chk("restart pulses", {62'd0, reset_state_timeout_counter_o, reset_SBmessage_retry_timeout}, 64'd3);
    chk("restart rx_req", 64'(SB_RX_msg_req_o), 64'(1));

    chk("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  always @(negedge clk_100MHz)
    if (reset_n && ACTIVE_RESP_done_o && ACTIVE_RESP_error_o) begin
      n_total++;
      $error("FAIL done_error_exclusive observed=11 expected=not both");
    end
endmodule
